// File: rtl/basys_mem_ctrl.sv
// Button-driven 16-bit memory controller: debounced buttons issue
// write/read/address commands to an external synchronous memory.
module basys_mem_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       SW,
  input  logic [4:0]        BTN,
  output logic [15:0]       LED,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [15:0]       MEM_RDATA,
  output logic              BUSY
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_e;

  state_e state_q, state_d;

  logic [4:0]        deb_q, deb_d;
  logic [4:0]        pulse_q, pulse_d;
  logic [CW-1:0]     cnt_q [5];
  logic [CW-1:0]     cnt_d [5];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       led_q, led_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              busy_q, busy_d;

  // Level flips on the DEB_CYCLES-th consecutive disagreeing sample
  always_comb begin
    deb_d   = deb_q;
    pulse_d = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (BTN[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]   = BTN[i];
          pulse_d[i] = BTN[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    led_d   = led_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          pulse_q[0]: begin
            wdata_d = SW;
            we_d    = 1'b1;
            state_d = S_WRITE;
          end
          pulse_q[1]: begin
            re_d    = 1'b1;
            state_d = S_READ;
          end
          pulse_q[2]: addr_d = addr_q + 1'b1;
          pulse_q[3]: addr_d = addr_q - 1'b1;
          pulse_q[4]: addr_d = '0;
          default: ;
        endcase
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        led_d   = MEM_RDATA;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      deb_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  assign LED       = led_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_WE    = we_q;
  assign MEM_RE    = re_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_basys_mem_ctrl.sv
// Bench for basys_mem_ctrl: behavioural memory, command-level model,
// per-cycle output compare plus directed literal checks.
module tb_basys_mem_ctrl;

  localparam int DEB = 4;

  logic        CLK;
  logic        RST;
  logic [15:0] SW;
  logic [4:0]  BTN;
  logic [15:0] LED;
  logic [3:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_WE;
  logic        MEM_RE;
  logic [15:0] MEM_RDATA;
  logic        BUSY;

  basys_mem_ctrl #(.ADDR_W(4), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .BTN(BTN), .LED(LED),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with registered read data
  logic [15:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    MEM_RDATA = '0;
  end
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR];
  end

  // Strobe counters see the value held during the cycle just ended
  int         we_count = 0;
  int         re_count = 0;
  logic [3:0] last_we_addr = '0;
  always @(posedge CLK) begin
    if (MEM_WE) begin
      we_count++;
      last_we_addr = MEM_ADDR;
    end
    if (MEM_RE) re_count++;
  end

  // Command-level model: debounced presses become commands, each
  // command occupies the controller for a fixed number of cycles
  int          mrun [5];
  bit   [4:0]  mdeb, mpend;
  int          busy_left, led_cnt;
  logic [15:0] led_val, e_led, e_wdata;
  logic [3:0]  e_addr;
  bit          e_we, e_re, e_busy;
  logic [15:0] ref_mem [16];

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 5; i++) mrun[i] = 0;
    mdeb = '0; mpend = '0; busy_left = 0; led_cnt = 0;
    led_val = '0; e_led = '0; e_wdata = '0; e_addr = '0;
    e_we = 0; e_re = 0; e_busy = 0;
  end

  always @(posedge CLK) begin
    bit [4:0] np;
    np = '0;
    if (RST) begin
      for (int i = 0; i < 5; i++) mrun[i] = 0;
      mdeb = '0; mpend = '0; busy_left = 0; led_cnt = 0;
      e_led = '0; e_wdata = '0; e_addr = '0;
      e_we = 0; e_re = 0; e_busy = 0;
    end else begin
      e_we = 0;
      e_re = 0;
      if (led_cnt > 0) begin
        led_cnt--;
        if (led_cnt == 0) e_led = led_val;
      end
      if (busy_left > 0) busy_left--;
      else if (mpend != 0) begin
        if (mpend[0]) begin
          e_wdata = SW;
          ref_mem[e_addr] = SW;
          e_we = 1;
          busy_left = 1;
        end else if (mpend[1]) begin
          e_re = 1;
          busy_left = 2;
          led_cnt = 2;
          led_val = ref_mem[e_addr];
        end else if (mpend[2]) e_addr = 4'((int'(e_addr) + 1) % 16);
        else if (mpend[3]) e_addr = 4'((int'(e_addr) + 15) % 16);
        else e_addr = 4'd0;
      end
      e_busy = (busy_left > 0);
      for (int i = 0; i < 5; i++) begin
        if (BTN[i] != mdeb[i]) begin
          mrun[i]++;
          if (mrun[i] == DEB) begin
            mdeb[i] = BTN[i];
            mrun[i] = 0;
            np[i] = BTN[i];
          end
        end else mrun[i] = 0;
      end
      mpend = np;
    end
  end

  bit chk_en = 0;
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_led", LED, e_led);
      check("cyc_addr", {12'd0, MEM_ADDR}, {12'd0, e_addr});
      check("cyc_wdata", MEM_WDATA, e_wdata);
      check("cyc_we", {15'd0, MEM_WE}, {15'd0, e_we});
      check("cyc_re", {15'd0, MEM_RE}, {15'd0, e_re});
      check("cyc_busy", {15'd0, BUSY}, {15'd0, e_busy});
    end
  end

  task automatic press(input logic [4:0] b);
    BTN = b;
    repeat (8) @(negedge CLK);
    BTN = '0;
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    bit found;
    RST = 1'b1;
    BTN = '0;
    SW  = '0;
    @(negedge CLK);
    chk_en = 1;
    check("rst_led", LED, 16'h0000);
    check("rst_addr", {12'd0, MEM_ADDR}, 16'h0000);
    check("rst_busy", {15'd0, BUSY}, 16'h0000);
    check("rst_strobes", {14'd0, MEM_WE, MEM_RE}, 16'h0000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Write then read back at address 0
    SW = 16'h5555;
    we_count = 0;
    re_count = 0;
    press(5'b00001);
    check("wr_once", 16'(we_count), 16'd1);
    check("wr_addr0", {12'd0, last_we_addr}, 16'h0000);
    press(5'b00010);
    check("rd_once", 16'(re_count), 16'd1);
    check("rd_led", LED, 16'h5555);
    check("model_led", e_led, 16'h5555);

    // Address steps and isolation
    press(5'b00100);
    press(5'b00100);
    check("addr_inc2", {12'd0, MEM_ADDR}, 16'd2);
    SW = 16'hAAAA;
    press(5'b00001);
    check("wr_addr2", {12'd0, last_we_addr}, 16'd2);
    press(5'b01000);
    press(5'b01000);
    press(5'b00010);
    check("iso_addr", {12'd0, MEM_ADDR}, 16'd0);
    check("iso_led", LED, 16'h5555);

    // Bounce never settles long enough
    we_count = 0;
    for (int i = 0; i < 10; i++) begin
      BTN[0] = ~BTN[0];
      repeat (2) @(negedge CLK);
    end
    BTN = '0;
    repeat (10) @(negedge CLK);
    check("bounce_no_we", 16'(we_count), 16'd0);

    // Wrap below zero, then simultaneous write+read
    press(5'b10000);
    press(5'b01000);
    check("wrap_addr15", {12'd0, MEM_ADDR}, 16'd15);
    check("model_addr15", {12'd0, e_addr}, 16'd15);
    we_count = 0;
    re_count = 0;
    press(5'b00011);
    check("prio_we", 16'(we_count), 16'd1);
    check("prio_re", 16'(re_count), 16'd0);
    check("prio_addr", {12'd0, last_we_addr}, 16'd15);

    // Reset during READ, button kept held through release
    BTN = 5'b00010;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      found = MEM_RE;
    end
    check("rd_seen", {15'd0, found}, 16'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_re", {15'd0, MEM_RE}, 16'd0);
    check("mid_led", LED, 16'h0000);
    check("mid_addr", {12'd0, MEM_ADDR}, 16'd0);
    check("mid_busy", {15'd0, BUSY}, 16'd0);
    re_count = 0;
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check("held_rst_rd", 16'(re_count), 16'd1);
    BTN = '0;
    repeat (10) @(negedge CLK);
    check("held_rst_led", LED, 16'h5555);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basys_mem_ctrl.md
BASYS_MEM_CTRL -- requirements
Module: basys_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: memory address width, giving 2^ADDR_W words.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: consecutive stable cycles needed for a debounced button change.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all logic changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port SW, input, 16 bits: write data source.
REQ-006 SHALL have port BTN, input, 5 bits, raw buttons: [0] up=write, [1] left=read, [2] right=addr+1, [3] down=addr-1, [4] center=addr clear.
REQ-007 SHALL have port LED, output, 16 bits: last read data.
REQ-008 SHALL have port MEM_ADDR, output, ADDR_W bits: current address register.
REQ-009 SHALL have port MEM_WDATA, output, 16 bits: write data held for the memory.
REQ-010 SHALL have port MEM_WE, output, 1 bit: write strobe.
REQ-011 SHALL have port MEM_RE, output, 1 bit: read strobe.
REQ-012 SHALL have port MEM_RDATA, input, 16 bits: read data, valid in the cycle after MEM_RE.
REQ-013 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 Each BTN bit SHALL have its own debouncer.
- Debounced level changes only after the raw input differs from it for DEB_CYCLES consecutive edges.
- Any agreeing sample resets that debouncer's counter.
REQ-015 A debounced 0->1 transition SHALL produce a one-cycle command pulse; a 1->0 transition produces nothing.
REQ-016 The FSM SHALL have states IDLE, WRITE, READ and CAPTURE.
REQ-017 Commands SHALL be accepted only in IDLE; pulses arriving in any other state are discarded, not queued.
REQ-018 Simultaneous pulses SHALL resolve by priority write > read > inc > dec > clear; lower-priority pulses in that cycle are discarded.
REQ-019 Write pulse in IDLE: MEM_WDATA SHALL load SW on that edge and the FSM goes to WRITE.
REQ-020 WRITE SHALL assert MEM_WE for exactly one cycle, then return to IDLE.
REQ-021 Read pulse in IDLE: the FSM SHALL go to READ, which asserts MEM_RE for exactly one cycle, then goes to CAPTURE.
REQ-022 At the edge ending CAPTURE, LED SHALL load MEM_RDATA and the FSM returns to IDLE.
REQ-023 Inc, dec and clear SHALL update MEM_ADDR on the accepting edge; the FSM stays in IDLE and BUSY stays low.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W: inc from 2^ADDR_W-1 gives 0, dec from 0 gives 2^ADDR_W-1, clear gives 0.
REQ-025 MEM_ADDR and MEM_WDATA SHALL be stable throughout WRITE, READ and CAPTURE.
REQ-026 MEM_WE and MEM_RE SHALL never be high in the same cycle.
REQ-027 Cycle-level latency, with pulse high in cycle k:
- MEM_WE (or MEM_RE) high in cycle k+1;
- LED new value visible from cycle k+3.
REQ-028 A button held continuously SHALL generate exactly one command.

Reset
REQ-029 With RST high at an edge, the block SHALL set the following:
- state=IDLE;
- LED, MEM_ADDR and MEM_WDATA = 0;
- MEM_WE, MEM_RE and BUSY = 0;
- all debounced levels and counters = 0;
- all pending pulses cleared.
REQ-030 RST SHALL override any operation in progress; strobes are low in the cycle after the reset edge and no LED capture occurs.
REQ-031 A button held through reset release SHALL be treated as a new press: one command after DEB_CYCLES stable cycles.

Verification
REQ-032 Bench SHALL use DEB_CYCLES=4 with a 16x16 behavioural memory model giving registered read data one cycle after MEM_RE.
REQ-033 Write/read-back: SW=16'h5555, up held 8 cycles, release, left held 8 cycles -> one MEM_WE pulse at addr 0, then LED==16'h5555 within 3 cycles of the read pulse.
REQ-034 Address steps and isolation, each step held 8 cycles:
- stimulus: right twice, SW=16'hAAAA, up, down twice, left;
- required response: write lands at addr 2, and LED==16'h5555 (addr 0 unchanged).
REQ-035 Bounce: up toggling every 2 cycles for 20 cycles -> MEM_WE never asserted.
REQ-036 Wrap and priority:
- clear, then down -> MEM_ADDR==15;
- up and left pressed together -> exactly one MEM_WE, no MEM_RE.
REQ-037 Reset mid-read: RST asserted in the READ cycle -> MEM_RE low next cycle, LED==0, MEM_ADDR==0, BUSY==0.
